// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: hex glyph patterns ({g,f,e,d,c,b,a}, 1 = lit),
// the load-handshake state type and the hex decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    LD_IDLE    = 1'b0,
    LD_PENDING = 1'b1
  } load_state_e;

  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    seg7_decode = SEG_0;
      4'h1:    seg7_decode = SEG_1;
      4'h2:    seg7_decode = SEG_2;
      4'h3:    seg7_decode = SEG_3;
      4'h4:    seg7_decode = SEG_4;
      4'h5:    seg7_decode = SEG_5;
      4'h6:    seg7_decode = SEG_6;
      4'h7:    seg7_decode = SEG_7;
      4'h8:    seg7_decode = SEG_8;
      4'h9:    seg7_decode = SEG_9;
      4'hA:    seg7_decode = SEG_A;
      4'hB:    seg7_decode = SEG_B;
      4'hC:    seg7_decode = SEG_C;
      4'hD:    seg7_decode = SEG_D;
      4'hE:    seg7_decode = SEG_E;
      4'hF:    seg7_decode = SEG_F;
      default: seg7_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bundle between the status-register side (master) and the scan driver (slave).
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] data_i;
  logic [NUM_DIGITS-1:0]   dp_i;
  logic [NUM_DIGITS-1:0]   blink_i;
  logic                    load_i;
  logic                    load_ack_o;
  logic                    lz_en_i;
  logic                    enable_i;
  logic [7:0]              seg_o;
  logic [NUM_DIGITS-1:0]   seg_sel_o;

  modport master (
    output data_i, dp_i, blink_i, load_i, lz_en_i, enable_i,
    input  load_ack_o, seg_o, seg_sel_o
  );

  modport slave (
    input  data_i, dp_i, blink_i, load_i, lz_en_i, enable_i,
    output load_ack_o, seg_o, seg_sel_o
  );
endinterface

// File: rtl/seg7_lz_mask.sv
// Leading-zero blank mask: digit i is blanked while nibbles 0..i are all zero,
// except the last digit, which always shows.
module seg7_lz_mask #(
  parameter int NUM_DIGITS = 8
) (
  input  logic [4*NUM_DIGITS-1:0] data_i,
  output logic [NUM_DIGITS-1:0]   blank_o
);
  // Prefix-OR of "nibble non-zero", running from the leftmost digit.
  logic [NUM_DIGITS-1:0] nz;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic nib_nz;
      assign nib_nz = |data_i[4*(NUM_DIGITS-gi)-1 -: 4];
      if (gi == 0) begin : g_first
        assign nz[gi] = nib_nz;
      end else begin : g_rest
        assign nz[gi] = nz[gi-1] | nib_nz;
      end
      assign blank_o[gi] = ~nz[gi] & (gi < NUM_DIGITS - 1);
    end
  endgenerate
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver: self-timed scan, tear-free double-buffered
// load, leading-zero blanking, per-digit dp/blink and a global enable.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic              clock_i,
  input  logic              reset_i,
  seg7_scan_driver_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [7:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_INV = (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [FW-1:0]           frame_q, frame_d;
  logic                    blink_phase_q, blink_phase_d;
  load_state_e             state_q, state_d;
  logic                    load_ack_q, load_ack_d;
  logic [4*NUM_DIGITS-1:0] sh_data_q, sh_data_d, act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   sh_blink_q, sh_blink_d, act_blink_q, act_blink_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   seg_sel_q, seg_sel_d;

  logic                    tick, frame_end, transfer;
  logic [NUM_DIGITS-1:0]   lz_blank, dark;
  logic [7:0]              digit_seg [NUM_DIGITS];

  seg7_lz_mask #(.NUM_DIGITS(NUM_DIGITS)) u_lz_mask (
    .data_i  (act_data_q),
    .blank_o (lz_blank)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_seg[gi] = {act_dp_q[gi], seg7_decode(act_data_q[4*(NUM_DIGITS-gi)-1 -: 4])};
      assign dark[gi] = (act_blink_q[gi] & blink_phase_q)
                      | (bus.lz_en_i & lz_blank[gi] & ~act_dp_q[gi]);
    end
  endgenerate

  assign tick      = (presc_q == PW'(REFRESH_DIV - 1));
  assign frame_end = tick && (idx_q == IW'(NUM_DIGITS - 1));
  assign transfer  = frame_end && (state_q == LD_PENDING);

  always_comb begin
    presc_d       = tick ? '0 : presc_q + PW'(1);
    idx_d         = idx_q;
    frame_d       = frame_q;
    blink_phase_d = blink_phase_q;
    if (tick) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    if (frame_end) begin
      if (frame_q == FW'(BLINK_FRAMES - 1)) begin
        frame_d       = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  // A load coinciding with a transfer lands in the shadow after the old shadow moves out.
  always_comb begin
    state_d     = state_q;
    load_ack_d  = transfer;
    sh_data_d   = sh_data_q;
    sh_dp_d     = sh_dp_q;
    sh_blink_d  = sh_blink_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_blink_d = act_blink_q;
    if (transfer) begin
      act_data_d  = sh_data_q;
      act_dp_d    = sh_dp_q;
      act_blink_d = sh_blink_q;
      state_d     = LD_IDLE;
    end
    if (bus.load_i) begin
      sh_data_d  = bus.data_i;
      sh_dp_d    = bus.dp_i;
      sh_blink_d = bus.blink_i;
      state_d    = LD_PENDING;
    end
  end

  // Each tick latches digit idx_q, so the frame_end slot still shows the old active set.
  always_comb begin
    seg_d     = seg_q;
    seg_sel_d = seg_sel_q;
    if (tick) begin
      seg_d     = SEG_INV;
      seg_sel_d = SEL_INV;
      if (bus.enable_i) begin
        seg_sel_d[idx_q] = ~SEL_INV[idx_q];
        if (!dark[idx_q]) seg_d = digit_seg[idx_q] ^ SEG_INV;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      presc_q       <= '0;
      idx_q         <= '0;
      frame_q       <= '0;
      blink_phase_q <= 1'b0;
      state_q       <= LD_IDLE;
      load_ack_q    <= 1'b0;
      sh_data_q     <= '0;
      sh_dp_q       <= '0;
      sh_blink_q    <= '0;
      act_data_q    <= '0;
      act_dp_q      <= '0;
      act_blink_q   <= '0;
      seg_q         <= SEG_INV;
      seg_sel_q     <= SEL_INV;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      frame_q       <= frame_d;
      blink_phase_q <= blink_phase_d;
      state_q       <= state_d;
      load_ack_q    <= load_ack_d;
      sh_data_q     <= sh_data_d;
      sh_dp_q       <= sh_dp_d;
      sh_blink_q    <= sh_blink_d;
      act_data_q    <= act_data_d;
      act_dp_q      <= act_dp_d;
      act_blink_q   <= act_blink_d;
      seg_q         <= seg_d;
      seg_sel_q     <= seg_sel_d;
    end
  end

  assign bus.load_ack_o = load_ack_q;
  assign bus.seg_o      = seg_q;
  assign bus.seg_sel_o  = seg_sel_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (8 digits, 4-cycle slots, 2-frame blink).
// pos counts rising edges since reset release; digit d of frame f latches at pos 4+32f+4d.
module tb_seg7_scan_driver;
  localparam int ND = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   pos    = 0;
  int   checks = 0;
  int   passes = 0;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS     (ND),
    .REFRESH_DIV    (4),
    .BLINK_FRAMES   (2),
    .SEG_ACTIVE_LOW (0),
    .SEL_ACTIVE_LOW (0)
  ) dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    pos += n;
  endtask

  task automatic goto(input int t);
    if (t > pos) step(t - pos);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pos   = 0;
    $display("reset released after %0d cycles", n);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b);
    bus.data_i  = d;
    bus.dp_i    = p;
    bus.blink_i = b;
    bus.load_i  = 1'b1;
    step(1);
    bus.load_i  = 1'b0;
    $display("load data=%h dp=%h blink=%h captured at pos %0d", d, p, b, pos);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (bus.seg_o !== 8'h00) $display("FAIL reset_seg: got %h want 00", bus.seg_o); else passes++;
    checks++; if (bus.seg_sel_o !== 8'h00) $display("FAIL reset_sel: got %h want 00", bus.seg_sel_o); else passes++;
    checks++; if (bus.load_ack_o !== 1'b0) $display("FAIL reset_ack: got %b want 0", bus.load_ack_o); else passes++;
    rst_n = 1'b1;
    pos   = 0;
    goto(3);
    checks++; if (bus.seg_sel_o !== 8'h00) $display("FAIL pre_tick_sel: got %h want 00", bus.seg_sel_o); else passes++;
    for (int d = 0; d < ND; d++) begin
      logic [7:0] want_sel;
      want_sel = 8'h01 << d;
      goto(4 + 4 * d);
      checks++; if (bus.seg_sel_o !== want_sel) $display("FAIL scan_sel d%0d: got %h want %h", d, bus.seg_sel_o, want_sel); else passes++;
      checks++; if (bus.seg_o !== 8'h3F) $display("FAIL scan_seg d%0d: got %h want 3f", d, bus.seg_o); else passes++;
    end
    goto(36);
    checks++; if (bus.seg_sel_o !== 8'h01) $display("FAIL wrap_sel: got %h want 01", bus.seg_sel_o); else passes++;
  endtask

  task automatic test_load();
    logic [7:0] want [ND];
    want = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h77, 8'h7C, 8'h39, 8'h5E};
    do_reset(2);
    goto(10);
    do_load(32'h0123_ABCD, 8'h00, 8'h00);
    goto(12);
    checks++; if (bus.seg_o !== 8'h3F) $display("FAIL load_midframe: got %h want 3f", bus.seg_o); else passes++;
    goto(31);
    checks++; if (bus.load_ack_o !== 1'b0) $display("FAIL load_ack_early: got %b want 0", bus.load_ack_o); else passes++;
    goto(32);
    checks++; if (bus.load_ack_o !== 1'b1) $display("FAIL load_ack: got %b want 1", bus.load_ack_o); else passes++;
    checks++; if (bus.seg_o !== 8'h3F) $display("FAIL load_last_old: got %h want 3f", bus.seg_o); else passes++;
    goto(33);
    checks++; if (bus.load_ack_o !== 1'b0) $display("FAIL load_ack_width: got %b want 0", bus.load_ack_o); else passes++;
    for (int d = 0; d < ND; d++) begin
      goto(36 + 4 * d);
      checks++; if (bus.seg_o !== want[d]) $display("FAIL load_digit d%0d: got %h want %h", d, bus.seg_o, want[d]); else passes++;
    end
  endtask

  task automatic test_lz();
    logic [7:0] want1 [ND];
    logic [7:0] want3 [ND];
    want1 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h6D, 8'h3F};
    want3 = '{8'h00, 8'hBF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3F};
    do_reset(2);
    bus.lz_en_i = 1'b1;
    do_load(32'h0000_0050, 8'h00, 8'h00);
    for (int d = 0; d < ND; d++) begin
      goto(36 + 4 * d);
      checks++; if (bus.seg_o !== want1[d]) $display("FAIL lz_50 d%0d: got %h want %h", d, bus.seg_o, want1[d]); else passes++;
    end
    goto(65);
    do_load(32'h0000_0000, 8'h00, 8'h00);
    for (int d = 0; d < ND; d++) begin
      logic [7:0] w;
      w = (d == ND - 1) ? 8'h3F : 8'h00;
      goto(100 + 4 * d);
      checks++; if (bus.seg_o !== w) $display("FAIL lz_zero d%0d: got %h want %h", d, bus.seg_o, w); else passes++;
    end
    goto(129);
    do_load(32'h0000_0000, 8'h02, 8'h00);
    for (int d = 0; d < ND; d++) begin
      goto(164 + 4 * d);
      checks++; if (bus.seg_o !== want3[d]) $display("FAIL lz_dp d%0d: got %h want %h", d, bus.seg_o, want3[d]); else passes++;
    end
    bus.lz_en_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset(2);
    do_load(32'h1111_1111, 8'h00, 8'h00);
    goto(31);
    do_load(32'h2222_2222, 8'h00, 8'h00);
    checks++; if (bus.load_ack_o !== 1'b1) $display("FAIL b2b_ack1: got %b want 1", bus.load_ack_o); else passes++;
    goto(33);
    checks++; if (bus.load_ack_o !== 1'b0) $display("FAIL b2b_ack1_width: got %b want 0", bus.load_ack_o); else passes++;
    goto(36);
    checks++; if (bus.seg_o !== 8'h06) $display("FAIL b2b_old_d0: got %h want 06", bus.seg_o); else passes++;
    goto(60);
    checks++; if (bus.seg_o !== 8'h06) $display("FAIL b2b_old_d6: got %h want 06", bus.seg_o); else passes++;
    goto(64);
    checks++; if (bus.load_ack_o !== 1'b1) $display("FAIL b2b_ack2: got %b want 1", bus.load_ack_o); else passes++;
    checks++; if (bus.seg_o !== 8'h06) $display("FAIL b2b_old_d7: got %h want 06", bus.seg_o); else passes++;
    goto(65);
    checks++; if (bus.load_ack_o !== 1'b0) $display("FAIL b2b_ack2_width: got %b want 0", bus.load_ack_o); else passes++;
    goto(68);
    checks++; if (bus.seg_o !== 8'h5B) $display("FAIL b2b_new_d0: got %h want 5b", bus.seg_o); else passes++;
    goto(70);
    do_load(32'h3333_3333, 8'h00, 8'h00);
    goto(72);
    do_load(32'h4444_4444, 8'h00, 8'h00);
    goto(96);
    checks++; if (bus.load_ack_o !== 1'b1) $display("FAIL lastwins_ack: got %b want 1", bus.load_ack_o); else passes++;
    goto(100);
    checks++; if (bus.seg_o !== 8'h66) $display("FAIL lastwins_d0: got %h want 66", bus.seg_o); else passes++;
    goto(128);
    checks++; if (bus.seg_o !== 8'h66) $display("FAIL lastwins_d7: got %h want 66", bus.seg_o); else passes++;
  endtask

  task automatic test_blink();
    do_reset(2);
    do_load(32'h8888_8888, 8'h80, 8'h01);
    for (int f = 1; f <= 6; f++) begin
      logic [7:0] w;
      w = (((f / 2) % 2) == 0) ? 8'h7F : 8'h00;
      goto(4 + 32 * f);
      checks++; if (bus.seg_o !== w) $display("FAIL blink_d0 f%0d: got %h want %h", f, bus.seg_o, w); else passes++;
      goto(32 + 32 * f);
      checks++; if (bus.seg_o !== 8'hFF) $display("FAIL blink_d7 f%0d: got %h want ff", f, bus.seg_o); else passes++;
    end
    bus.dp_i    = 8'h00;
    bus.blink_i = 8'h00;
  endtask

  task automatic test_enable();
    do_reset(2);
    do_load(32'h0123_4567, 8'h00, 8'h00);
    goto(44);
    checks++; if (bus.seg_sel_o !== 8'h04) $display("FAIL en_before_sel: got %h want 04", bus.seg_sel_o); else passes++;
    bus.enable_i = 1'b0;
    goto(46);
    checks++; if (bus.seg_sel_o !== 8'h04) $display("FAIL en_hold_sel: got %h want 04", bus.seg_sel_o); else passes++;
    checks++; if (bus.seg_o !== 8'h5B) $display("FAIL en_hold_seg: got %h want 5b", bus.seg_o); else passes++;
    for (int t = 48; t <= 56; t += 4) begin
      goto(t);
      checks++; if (bus.seg_sel_o !== 8'h00) $display("FAIL en_off_sel pos%0d: got %h want 00", t, bus.seg_sel_o); else passes++;
      checks++; if (bus.seg_o !== 8'h00) $display("FAIL en_off_seg pos%0d: got %h want 00", t, bus.seg_o); else passes++;
    end
    bus.enable_i = 1'b1;
    goto(60);
    checks++; if (bus.seg_sel_o !== 8'h40) $display("FAIL en_resume_sel: got %h want 40", bus.seg_sel_o); else passes++;
    checks++; if (bus.seg_o !== 8'h7D) $display("FAIL en_resume_seg: got %h want 7d", bus.seg_o); else passes++;
    goto(61);
    do_load(32'h89AB_CDEF, 8'hFF, 8'h00);
    goto(63);
    rst_n = 1'b0;
    step(1);
    checks++; if (bus.load_ack_o !== 1'b0) $display("FAIL rst_pending_ack: got %b want 0", bus.load_ack_o); else passes++;
    checks++; if (bus.seg_sel_o !== 8'h00) $display("FAIL rst_mid_sel: got %h want 00", bus.seg_sel_o); else passes++;
    step(2);
    rst_n = 1'b1;
    pos   = 0;
    goto(4);
    checks++; if (bus.seg_o !== 8'h3F) $display("FAIL rst_active_d0: got %h want 3f", bus.seg_o); else passes++;
    goto(32);
    checks++; if (bus.load_ack_o !== 1'b0) $display("FAIL rst_dropped_ack: got %b want 0", bus.load_ack_o); else passes++;
    goto(36);
    checks++; if (bus.seg_o !== 8'h3F) $display("FAIL rst_dropped_d0: got %h want 3f", bus.seg_o); else passes++;
  endtask

  initial begin
    bus.data_i   = '0;
    bus.dp_i     = '0;
    bus.blink_i  = '0;
    bus.load_i   = 1'b0;
    bus.lz_en_i  = 1'b0;
    bus.enable_i = 1'b1;
    test_reset();
    test_load();
    test_lz();
    test_back_to_back();
    test_blink();
    test_enable();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
